// File: rtl/sobel_data_buffer.sv
// -----------------------------------------------------------------------------
// sobel_data_buffer
//
// Streaming 3x3 window generator for the Sobel edge-detection pipeline.
// Pixels arrive one per qualified cycle in raster order. The two previous
// rows are kept in line buffers. Whenever the newest pixel completes a full
// 3x3 neighbourhood inside the current frame, the neighbourhood is presented
// on d0_o..d8_o together with a one-cycle done_o strobe.
//
// Ports
//   clk          system clock, rising-edge active
//   rst          synchronous reset, active low
//   grayscale_i  incoming pixel (raster order)
//   done_i       pixel-valid qualifier; grayscale_i accepted when high
//   d0_o..d2_o   window top row, left to right (oldest row)
//   d3_o..d5_o   window middle row
//   d6_o..d8_o   window bottom row; d8_o is the newest pixel
//   done_o       window-valid strobe, one cycle per valid window
// -----------------------------------------------------------------------------
module sobel_data_buffer #(
    parameter int IMG_WIDTH  = 6,
    parameter int IMG_HEIGHT = 6,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] grayscale_i,
    input  logic              done_i,
    output logic [DATA_W-1:0] d0_o,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic [DATA_W-1:0] d3_o,
    output logic [DATA_W-1:0] d4_o,
    output logic [DATA_W-1:0] d5_o,
    output logic [DATA_W-1:0] d6_o,
    output logic [DATA_W-1:0] d7_o,
    output logic [DATA_W-1:0] d8_o,
    output logic              done_o
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // Position of the pixel that will be accepted next.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // lb0 holds the previous row, lb1 the row before that.
    logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];

    logic [DATA_W-1:0] w_q [9];
    logic [DATA_W-1:0] w_d [9];
    logic              done_q, done_d;

    logic              col_last;
    logic              row_last;
    logic              win_ok;
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

    // A window is only complete once two earlier rows and two earlier
    // columns of the same row exist; this also hides stale line-buffer data
    // left over from a previous frame or from before reset.
    assign win_ok = (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign lb0_rd = lb0_q[col_q];
    assign lb1_rd = lb1_q[col_q];

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        done_d = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w_d[i] = w_q[i];
        end

        if (done_i) begin
            // Each window row shifts left; the new column enters on the right.
            w_d[0] = w_q[1];
            w_d[1] = w_q[2];
            w_d[2] = lb1_rd;
            w_d[3] = w_q[4];
            w_d[4] = w_q[5];
            w_d[5] = lb0_rd;
            w_d[6] = w_q[7];
            w_d[7] = w_q[8];
            w_d[8] = grayscale_i;

            done_d = win_ok;

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            done_q <= done_d;
            for (int i = 0; i < 9; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // Line buffers carry no reset; their contents only matter once the row
    // counter has moved past them.
    always_ff @(posedge clk) begin
        if (done_i) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= grayscale_i;
        end
    end

    assign d0_o   = w_q[0];
    assign d1_o   = w_q[1];
    assign d2_o   = w_q[2];
    assign d3_o   = w_q[3];
    assign d4_o   = w_q[4];
    assign d5_o   = w_q[5];
    assign d6_o   = w_q[6];
    assign d7_o   = w_q[7];
    assign d8_o   = w_q[8];
    assign done_o = done_q;

endmodule

// File: tb/tb_sobel_data_buffer.sv
module tb_sobel_data_buffer;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int DW = 8;

    typedef logic [9*DW-1:0] win_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] gray = '0;
    logic          done_i = 1'b0;
    logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic          done_o;

    always #5 clk = ~clk;

    sobel_data_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .grayscale_i (gray),
        .done_i      (done_i),
        .d0_o        (d0),
        .d1_o        (d1),
        .d2_o        (d2),
        .d3_o        (d3),
        .d4_o        (d4),
        .d5_o        (d5),
        .d6_o        (d6),
        .d7_o        (d7),
        .d8_o        (d8),
        .done_o      (done_o)
    );

    win_t act;
    assign act = {d0, d1, d2, d3, d4, d5, d6, d7, d8};

    int   tests = 0;
    int   fails = 0;
    win_t exp_q[$];
    win_t log_q[$];
    win_t last_exp = '0;
    int   pulses = 0;

    function automatic win_t mk(input int a, input int b, input int c,
                                input int d, input int e, input int f,
                                input int g, input int h, input int i);
        return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i)};
    endfunction

    task automatic check_win(input string name, input win_t a, input win_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // Monitor: every presented window is popped against the scoreboard.
    always @(negedge clk) begin
        win_t e;
        if (done_o === 1'b1) begin
            pulses++;
            log_q.push_back(act);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_window: got %h expected none", act);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                check_win("window", act, e);
            end
        end
    end

    task automatic send_pixel(input int v);
        gray   = DW'(v);
        done_i = 1'b1;
        @(posedge clk);
        #1;
        done_i = 1'b0;
    endtask

    task automatic stall(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_win("stall_hold", act, last_exp);
            check_int("stall_done_low", int'(done_o), 0);
        end
    endtask

    // Streams npix pixels of a frame whose pixel (r,c) has value base+r*W+c+1,
    // pushing the expected window for every pixel that completes one.
    task automatic stream_frame(input int base, input bit stalls, input int npix);
        int   r, c, v;
        win_t w;
        for (int idx = 0; idx < npix; idx++) begin
            r = idx / W;
            c = idx % W;
            if (r >= 2 && c >= 2) begin
                w = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        v = base + (r - 2 + i) * W + (c - 2 + j) + 1;
                        w = {w[8*DW-1:0], DW'(v)};
                    end
                end
                exp_q.push_back(w);
            end
            send_pixel(base + idx + 1);
            if (stalls && (idx + 1 == 16 || idx + 1 == 24)) stall(3);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        done_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_win("reset_outputs", act, '0);
        check_int("reset_done", int'(done_o), 0);
        rst = 1'b1;
    endtask

    task automatic drain_and_count(input string name, input int exp_pulses);
        @(posedge clk);
        #1;
        check_int(name, pulses, exp_pulses);
        check_int("queue_empty", exp_q.size(), 0);
    endtask

    task automatic start_test();
        log_q.delete();
        pulses = 0;
    endtask

    task automatic check_frame1_log(input string tag);
        if (log_q.size() >= 16) begin
            check_win({tag, "_first"}, log_q[0],  mk(1, 2, 3, 7, 8, 9, 13, 14, 15));
            check_win({tag, "_row3"},  log_q[4],  mk(7, 8, 9, 13, 14, 15, 19, 20, 21));
            check_win({tag, "_last"},  log_q[15], mk(22, 23, 24, 28, 29, 30, 34, 35, 36));
        end else begin
            check_int({tag, "_log_size"}, log_q.size(), 16);
        end
    endtask

    initial begin
        // Reset values
        do_reset();

        // Full continuous frame
        start_test();
        stream_frame(0, 1'b0, 36);
        drain_and_count("full_pulses", 16);
        check_frame1_log("full");

        // Same frame with stalls after pixels 16 and 24
        do_reset();
        start_test();
        stream_frame(0, 1'b1, 36);
        drain_and_count("stall_pulses", 16);
        check_frame1_log("stall");

        // Reset mid-frame after pixel 20, then a full frame
        do_reset();
        start_test();
        stream_frame(0, 1'b0, 20);
        drain_and_count("partial_pulses", 4);
        do_reset();
        start_test();
        stream_frame(0, 1'b0, 36);
        drain_and_count("after_reset_pulses", 16);
        check_frame1_log("midrst");

        // Back-to-back frames
        do_reset();
        start_test();
        stream_frame(0, 1'b0, 36);
        stream_frame(100, 1'b0, 36);
        drain_and_count("b2b_pulses", 32);
        if (log_q.size() >= 32) begin
            check_win("b2b_f2_first", log_q[16], mk(101, 102, 103, 107, 108, 109, 113, 114, 115));
            check_win("b2b_f2_last",  log_q[31], mk(122, 123, 124, 128, 129, 130, 134, 135, 136));
        end else begin
            check_int("b2b_log_size", log_q.size(), 32);
        end

        // Outputs hold while idle after the last window
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_win("idle_hold", act, mk(122, 123, 124, 128, 129, 130, 134, 135, 136));
        check_int("idle_done_low", int'(done_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
